router_fifo: RTL and testbench

Per-destination output FIFO of the 1x3 router. It sits directly downstream of the register stage. It captures each byte driven by the register stage (header, payload, parity), tagged with a header marker taken from lfd_state, and presents it to the destination read port. One instance exists per output channel. It also tracks the remaining packet length so data_out returns to 0 once a packet has been fully drained.

---
 rtl/router_fifo.sv | 90 +++++++++
 tb/tb_router_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores header-tagged bytes and
// tracks remaining packet length so data_out returns to zero once a packet is drained.
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

    logic [DWIDTH:0]   mem_q [DEPTH];
    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [6:0]        pkt_cnt_q, pkt_cnt_d;
    logic [DWIDTH-1:0] data_out_q, data_out_d;
    logic [DWIDTH:0]   rd_word;
    logic              wr_acc, rd_acc;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                     (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem_q[rd_ptr_q[AWIDTH-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_word[DWIDTH-1:0];
                // Header byte carries payload length in [7:2]; +1 accounts for parity.
                if (rd_word[DWIDTH])
                    pkt_cnt_d = 7'(rd_word[DWIDTH-1:2]) + 7'd1;
                else if (pkt_cnt_q != 7'd0)
                    pkt_cnt_d = pkt_cnt_q - 7'd1;
            end else if (pkt_cnt_q == 7'd0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Soft reset only clears header markers; stale data is unreachable once pointers reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (soft_reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i][DWIDTH] <= 1'b0;
        end else if (wr_acc) begin
            mem_q[wr_ptr_q[AWIDTH-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: stimulus pushes expected read bytes into a queue,
// a monitor pops and compares whenever a read is accepted.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    router_fifo #(.DEPTH(16), .AWIDTH(4), .DWIDTH(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: decide acceptance just before the edge, compare just after it.
    initial begin
        logic acc;
        logic [7:0] exp;
        forever begin
            @(negedge clock);
            #4;
            acc = resetn && !soft_reset && read_enb && !empty;
            @(posedge clock);
            #1;
            if (acc) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_data: unexpected read got %02h required none", data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (data_out !== exp) begin
                        errors++;
                        $display("FAIL read_data: got %02h required %02h", data_out, exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] d);
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = d;
        @(negedge clock);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        cyc(1'b1, 1'b0, lfd, d);
    endtask

    task automatic rd();
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        @(negedge clock);
        chk("reset_data_out", data_out, 8'h00);
        chk("reset_empty", {7'd0, empty}, 8'h01);
        chk("reset_full", {7'd0, full}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Single packet: header 0x0D -> length 3 + parity
        wr(8'h0D, 1'b1); wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0); wr(8'h0D, 1'b0);
        chk("pkt_not_empty", {7'd0, empty}, 8'h00);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h0D);
        rd(); rd();
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("pkt_hold_midpacket", data_out, 8'h11);
        rd(); rd(); rd();
        chk("pkt_last_parity", data_out, 8'h0D);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("pkt_idle_zero", data_out, 8'h00);
        chk("pkt_empty", {7'd0, empty}, 8'h01);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        chk("fill_full", {7'd0, full}, 8'h01);
        chk("fill_not_empty", {7'd0, empty}, 8'h00);
        wr(8'hAA, 1'b0);
        chk("overflow_still_full", {7'd0, full}, 8'h01);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 16; i++) rd();
        chk("drain_empty", {7'd0, empty}, 8'h01);
        chk("drain_not_full", {7'd0, full}, 8'h00);

        // Simultaneous read+write at full: read wins, write dropped
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        exp_q.push_back(8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        chk("simfull_not_full", {7'd0, full}, 8'h00);
        wr(8'h55, 1'b0);
        chk("retry_full", {7'd0, full}, 8'h01);
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h55);
        for (int i = 0; i < 16; i++) rd();
        chk("simfull_drain_empty", {7'd0, empty}, 8'h01);

        // Simultaneous read+write when empty: write only, no fall-through
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        chk("simempty_not_empty", {7'd0, empty}, 8'h01 ^ 8'h01);
        exp_q.push_back(8'h77);
        rd();
        chk("simempty_after_read", {7'd0, empty}, 8'h01);

        // Wrap-around with concurrent traffic at occupancy 10
        for (int i = 0; i < 10; i++) begin
            wr(8'h20 + 8'(i), 1'b0);
            exp_q.push_back(8'h20 + 8'(i));
        end
        for (int i = 0; i < 30; i++) begin
            exp_q.push_back(8'h2A + 8'(i));
            cyc(1'b1, 1'b1, 1'b0, 8'h2A + 8'(i));
            chk("wrap_flags", {6'd0, full, empty}, 8'h00);
        end
        for (int i = 0; i < 10; i++) rd();
        chk("wrap_drain_empty", {7'd0, empty}, 8'h01);

        // Soft reset mid-packet discards contents and the concurrent write
        wr(8'h11, 1'b1); wr(8'h22, 1'b0); wr(8'h33, 1'b0);
        exp_q.push_back(8'h11);
        rd();
        soft_reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h99);
        soft_reset = 1'b0;
        chk("soft_empty", {7'd0, empty}, 8'h01);
        chk("soft_full", {7'd0, full}, 8'h00);
        chk("soft_data_out", data_out, 8'h00);
        rd();
        chk("soft_write_lost", {7'd0, empty}, 8'h01);
        chk("soft_idle_zero", data_out, 8'h00);
        wr(8'h44, 1'b0);
        exp_q.push_back(8'h44);
        rd();
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("soft_pktcnt_zero", data_out, 8'h00);

        // Asynchronous reset mid-packet
        wr(8'h3C, 1'b1); wr(8'h01, 1'b0);
        exp_q.push_back(8'h3C);
        rd();
        chk("pre_reset_data", data_out, 8'h3C);
        #2 resetn = 1'b0;
        #1;
        chk("async_data_out", data_out, 8'h00);
        chk("async_empty", {7'd0, empty}, 8'h01);
        chk("async_full", {7'd0, full}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        rd();
        chk("post_reset_data", data_out, 8'h00);
        chk("post_reset_empty", {7'd0, empty}, 8'h01);

        repeat (3) @(negedge clock);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
